// File: rtl/raster_pkg.sv
// raster_pkg: shared types and default widths for the rasterizer edge-walk controller.
package raster_pkg;
  localparam int DEF_COORD_W = 10;
  localparam int DEF_COEF_W  = 11;
  localparam int DEF_CNT_W   = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ITER_START,
    S_INIT_E1,
    S_INIT_E2,
    S_EDGE_TEST,
    S_INTERPOLATE,
    S_ITER_NEXT
  } raster_walk_state_t;
  typedef enum logic [1:0] {
    EDGE0,
    EDGE1,
    EDGE2
  } edge_sel_t;
endpackage

// File: rtl/raster_walk_ctrl_if.sv
// raster_walk_ctrl_if: set-up triangle handshake, bounding box and edge coefficients.
interface raster_walk_ctrl_if import raster_pkg::*; #(
  parameter int COORD_W = DEF_COORD_W,
  parameter int COEF_W  = DEF_COEF_W
);
  logic               tri_valid;
  logic               tri_ready;
  logic [COORD_W-1:0] bbox_min_x;
  logic [COORD_W-1:0] bbox_min_y;
  logic [COORD_W-1:0] bbox_max_x;
  logic [COORD_W-1:0] bbox_max_y;
  logic [COEF_W-1:0]  edge0_A;
  logic [COEF_W-1:0]  edge0_B;
  logic [COEF_W-1:0]  edge1_A;
  logic [COEF_W-1:0]  edge1_B;
  logic [COEF_W-1:0]  edge2_A;
  logic [COEF_W-1:0]  edge2_B;
  modport master (
    output tri_valid, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y,
           edge0_A, edge0_B, edge1_A, edge1_B, edge2_A, edge2_B,
    input  tri_ready
  );
  modport slave (
    input  tri_valid, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y,
           edge0_A, edge0_B, edge1_A, edge1_B, edge2_A, edge2_B,
    output tri_ready
  );
endinterface

// File: rtl/raster_smul_opsel.sv
// raster_smul_opsel: 3:1 edge A/B operand mux feeding the shared setup multipliers.
module raster_smul_opsel import raster_pkg::*; #(
  parameter int COEF_W = DEF_COEF_W
) (
  input  edge_sel_t         sel_i,
  input  logic [COEF_W-1:0] e0_a_i,
  input  logic [COEF_W-1:0] e0_b_i,
  input  logic [COEF_W-1:0] e1_a_i,
  input  logic [COEF_W-1:0] e1_b_i,
  input  logic [COEF_W-1:0] e2_a_i,
  input  logic [COEF_W-1:0] e2_b_i,
  output logic [COEF_W-1:0] a_o,
  output logic [COEF_W-1:0] b_o
);
  always_comb begin
    a_o = sel_i == EDGE1 ? e1_a_i : sel_i == EDGE2 ? e2_a_i : e0_a_i;
    b_o = sel_i == EDGE1 ? e1_b_i : sel_i == EDGE2 ? e2_b_i : e0_b_i;
  end
endmodule

// File: rtl/raster_walk_ctrl.sv
// raster_walk_ctrl: sequences edge-walk strobes over a latched bbox and counts emitted fragments.
module raster_walk_ctrl import raster_pkg::*; #(
  parameter int COORD_W = DEF_COORD_W,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  raster_walk_ctrl_if.slave  tri_if,
  output logic [COEF_W-1:0]  smul_a1,
  output logic [COEF_W:0]    smul_b1,
  output logic [COEF_W-1:0]  smul_a2,
  output logic [COEF_W:0]    smul_b2,
  output logic               do_idle,
  output logic               init_pos_e0,
  output logic               init_e1,
  output logic               init_e2,
  output logic               do_interpolate,
  output logic               step_x,
  output logic               step_y,
  input  logic               inside_triangle,
  input  logic [COORD_W-1:0] curr_x,
  input  logic [COORD_W-1:0] curr_y,
  input  logic               frag_valid,
  input  logic               frag_ready,
  output logic               busy,
  output logic               tri_done,
  output logic [CNT_W-1:0]   frag_count
);
  raster_walk_state_t state_q, state_d;
  logic [COORD_W-1:0] min_x_q, min_y_q, max_x_q, max_y_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               accept, degen, hs, nxt, more_x, more_y;
  edge_sel_t          sel;
  assign accept = state_q == S_IDLE && tri_if.tri_valid;
  assign degen  = tri_if.bbox_max_x < tri_if.bbox_min_x || tri_if.bbox_max_y < tri_if.bbox_min_y;
  assign hs     = frag_valid && frag_ready;
  assign nxt    = state_q == S_ITER_NEXT;
  // Stepping is gated by strict less-than, so max=all-ones never wraps
  assign more_x = curr_x < max_x_q;
  assign more_y = curr_y < max_y_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        state_d = accept && !degen ? S_ITER_START : S_IDLE;
      S_ITER_START:  state_d = S_INIT_E1;
      S_INIT_E1:     state_d = S_INIT_E2;
      S_INIT_E2:     state_d = S_EDGE_TEST;
      S_EDGE_TEST:   state_d = inside_triangle ? S_INTERPOLATE : S_ITER_NEXT;
      S_INTERPOLATE: state_d = hs ? S_ITER_NEXT : S_INTERPOLATE;
      S_ITER_NEXT:   state_d = more_x || more_y ? S_EDGE_TEST : S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end
  always_comb begin
    cnt_d  = accept ? '0
           : state_q == S_INTERPOLATE && hs && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    done_d = accept && degen;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      min_x_q <= '0;
      min_y_q <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (accept) begin
        min_x_q <= tri_if.bbox_min_x;
        min_y_q <= tri_if.bbox_min_y;
        max_x_q <= tri_if.bbox_max_x;
        max_y_q <= tri_if.bbox_max_y;
      end
    end
  end
  assign tri_if.tri_ready = state_q == S_IDLE;
  assign busy             = state_q != S_IDLE;
  assign init_pos_e0      = state_q == S_ITER_START;
  assign init_e1          = state_q == S_INIT_E1;
  assign init_e2          = state_q == S_INIT_E2;
  assign do_interpolate   = state_q == S_INTERPOLATE;
  assign step_x           = nxt && more_x;
  assign step_y           = nxt && !more_x && more_y;
  assign do_idle          = nxt && !more_x && !more_y;
  assign tri_done         = done_q || do_idle;
  assign frag_count       = cnt_q;
  assign sel              = init_e1 ? EDGE1 : init_e2 ? EDGE2 : EDGE0;
  assign smul_b1          = (COEF_W+1)'(min_x_q);
  assign smul_b2          = (COEF_W+1)'(min_y_q);
  raster_smul_opsel #(.COEF_W(COEF_W)) u_opsel (
    .sel_i  (sel),
    .e0_a_i (tri_if.edge0_A),
    .e0_b_i (tri_if.edge0_B),
    .e1_a_i (tri_if.edge1_A),
    .e1_b_i (tri_if.edge1_B),
    .e2_a_i (tri_if.edge2_A),
    .e2_b_i (tri_if.edge2_B),
    .a_o    (smul_a1),
    .b_o    (smul_a2)
  );
endmodule

// File: tb/tb_raster_walk_ctrl.sv
// tb_raster_walk_ctrl: drives an edge-walk model and checks strobe timing, counts and operands.
module tb_raster_walk_ctrl;
  localparam int COORD_W = 10;
  localparam int COEF_W  = 11;
  localparam int CNT_W   = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic [COEF_W-1:0]  smul_a1, smul_a2;
  logic [COEF_W:0]    smul_b1, smul_b2;
  logic do_idle, init_pos_e0, init_e1, init_e2, do_interpolate, step_x, step_y;
  logic inside_triangle, frag_valid, frag_ready, busy, tri_done;
  logic [COORD_W-1:0] curr_x, curr_y;
  logic [CNT_W-1:0]   frag_count;
  int total = 0, bad = 0;
  int ins_mode = 0, salt = 0, stall_k = 0, stall_px_x = -1, stall_px_y = -1;
  raster_walk_ctrl_if #(.COORD_W(COORD_W), .COEF_W(COEF_W)) tif ();
  raster_walk_ctrl #(.COORD_W(COORD_W), .COEF_W(COEF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .tri_if(tif.slave),
    .smul_a1(smul_a1), .smul_b1(smul_b1), .smul_a2(smul_a2), .smul_b2(smul_b2),
    .do_idle(do_idle), .init_pos_e0(init_pos_e0), .init_e1(init_e1), .init_e2(init_e2),
    .do_interpolate(do_interpolate), .step_x(step_x), .step_y(step_y),
    .inside_triangle(inside_triangle), .curr_x(curr_x), .curr_y(curr_y),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .busy(busy), .tri_done(tri_done), .frag_count(frag_count)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  function automatic bit ins(int x, int y);
    return ins_mode == 0 ? 1'b1 : ins_mode == 1 ? (x == 2) : (((x * 7 + y * 13 + salt) % 3) != 0);
  endfunction
  function automatic int stall_of(int x, int y);
    return (stall_px_x < 0 || (x == stall_px_x && y == stall_px_y)) ? stall_k : 0;
  endfunction
  task automatic rand_edges();
    tif.edge0_A = COEF_W'($urandom); tif.edge0_B = COEF_W'($urandom);
    tif.edge1_A = COEF_W'($urandom); tif.edge1_B = COEF_W'($urandom);
    tif.edge2_A = COEF_W'($urandom); tif.edge2_B = COEF_W'($urandom);
  endtask
  task automatic run_tri(input string nm, input int mnx, input int mny, input int mxx, input int mxy);
    int exp_done, exp_fr, exp_sx, exp_sy, exp_int, cost;
    int cyc, done_cyc, sx, sy, ni, both, i0, i1, i2, other, wait_c, cx, cy, nx, ny, busy_err;
    bit degen, fvn;
    logic [COEF_W-1:0] ea [3];
    logic [COEF_W-1:0] eb [3];
    logic [COEF_W:0] eb1, eb2;
    degen = mxx < mnx || mxy < mny;
    exp_fr = 0; cost = 0; exp_int = 0;
    if (!degen)
      for (int y = mny; y <= mxy; y++)
        for (int x = mnx; x <= mxx; x++)
          if (ins(x, y)) begin
            exp_fr++; cost += 4 + stall_of(x, y); exp_int += 2 + stall_of(x, y);
          end else cost += 2;
    exp_done = degen ? 1 : 3 + cost;
    exp_sx = degen ? 0 : (mxx - mnx) * (mxy - mny + 1);
    exp_sy = degen ? 0 : mxy - mny;
    ea[0] = tif.edge0_A; ea[1] = tif.edge1_A; ea[2] = tif.edge2_A;
    eb[0] = tif.edge0_B; eb[1] = tif.edge1_B; eb[2] = tif.edge2_B;
    eb1 = (COEF_W+1)'(mnx); eb2 = (COEF_W+1)'(mny);
    @(posedge clk); #1;
    tif.bbox_min_x = COORD_W'(mnx); tif.bbox_min_y = COORD_W'(mny);
    tif.bbox_max_x = COORD_W'(mxx); tif.bbox_max_y = COORD_W'(mxy);
    tif.tri_valid = 1'b1;
    cx = 0; cy = 0; wait_c = 0;
    frag_valid = 1'b0; frag_ready = 1'b1; curr_x = '0; curr_y = '0; inside_triangle = ins(0, 0);
    cyc = 0; done_cyc = -1; sx = 0; sy = 0; ni = 0; both = 0; i0 = -1; i1 = -1; i2 = -1; other = 0; busy_err = 0;
    while (cyc < 4000 && done_cyc < 0) begin
      @(negedge clk);
      if (busy !== (!degen && cyc >= 1) || tif.tri_ready !== !busy) busy_err++;
      if (init_pos_e0) begin
        i0 = cyc; total++;
        if (smul_a1 !== ea[0] || smul_a2 !== eb[0] || smul_b1 !== eb1 || smul_b2 !== eb2) begin
          bad++; $display("FAIL %s op_e0 got %h/%h/%h/%h want %h/%h/%h/%h", nm, smul_a1, smul_b1, smul_a2, smul_b2, ea[0], eb1, eb[0], eb2);
        end
      end
      if (init_e1) begin
        i1 = cyc; total++;
        if (smul_a1 !== ea[1] || smul_a2 !== eb[1] || smul_b1 !== eb1 || smul_b2 !== eb2) begin
          bad++; $display("FAIL %s op_e1 got %h/%h/%h/%h want %h/%h/%h/%h", nm, smul_a1, smul_b1, smul_a2, smul_b2, ea[1], eb1, eb[1], eb2);
        end
      end
      if (init_e2) begin
        i2 = cyc; total++;
        if (smul_a1 !== ea[2] || smul_a2 !== eb[2] || smul_b1 !== eb1 || smul_b2 !== eb2) begin
          bad++; $display("FAIL %s op_e2 got %h/%h/%h/%h want %h/%h/%h/%h", nm, smul_a1, smul_b1, smul_a2, smul_b2, ea[2], eb1, eb[2], eb2);
        end
      end
      if (step_x) sx++;
      if (step_y) sy++;
      if (step_x && step_y) both++;
      if (do_interpolate) ni++;
      if (degen && (init_pos_e0 || init_e1 || init_e2 || do_interpolate || step_x || step_y || do_idle)) other++;
      if (tri_done) begin
        done_cyc = cyc; total++;
        if (do_idle !== !degen) begin
          bad++; $display("FAIL %s do_idle_at_done got %b want %b", nm, do_idle, !degen);
        end
      end
      fvn = do_interpolate && !(frag_valid && frag_ready);
      wait_c = (frag_valid && !frag_ready) ? wait_c + 1 : 0;
      nx = cx; ny = cy;
      if (init_pos_e0) begin nx = mnx; ny = mny; end
      if (step_x) nx = cx + 1;
      if (step_y) begin nx = mnx; ny = cy + 1; end
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        tif.tri_valid = 1'b0;
        tif.bbox_min_x = COORD_W'($urandom); tif.bbox_min_y = COORD_W'($urandom);
        tif.bbox_max_x = COORD_W'($urandom); tif.bbox_max_y = COORD_W'($urandom);
      end
      cx = nx; cy = ny;
      curr_x = COORD_W'(cx); curr_y = COORD_W'(cy);
      inside_triangle = ins(cx, cy);
      frag_valid = fvn;
      frag_ready = !fvn || wait_c >= stall_of(cx, cy);
    end
    total++;
    if (done_cyc !== exp_done) begin bad++; $display("FAIL %s done_cycle got %0d want %0d", nm, done_cyc, exp_done); end
    total++;
    if (frag_count !== CNT_W'(exp_fr)) begin bad++; $display("FAIL %s frag_count got %0d want %0d", nm, frag_count, exp_fr); end
    total++;
    if (sx !== exp_sx || sy !== exp_sy || both !== 0) begin
      bad++; $display("FAIL %s steps got x=%0d y=%0d both=%0d want x=%0d y=%0d both=0", nm, sx, sy, both, exp_sx, exp_sy);
    end
    total++;
    if (ni !== exp_int) begin bad++; $display("FAIL %s interp_cycles got %0d want %0d", nm, ni, exp_int); end
    total++;
    if (degen ? (i0 != -1 || i1 != -1 || i2 != -1 || other != 0) : (i0 != 1 || i1 != 2 || i2 != 3)) begin
      bad++; $display("FAIL %s init_cycles got %0d/%0d/%0d other=%0d want %s", nm, i0, i1, i2, other, degen ? "none" : "1/2/3");
    end
    total++;
    if (busy_err !== 0) begin bad++; $display("FAIL %s busy_ready got %0d errs want 0", nm, busy_err); end
    @(negedge clk);
    total++;
    if (tif.tri_ready !== 1'b1 || busy !== 1'b0 || tri_done !== 1'b0) begin
      bad++; $display("FAIL %s post_idle got ready=%b busy=%b done=%b want 1/0/0", nm, tif.tri_ready, busy, tri_done);
    end
  endtask
  task automatic test_reset();
    tif.tri_valid = 1'b0; frag_valid = 1'b0; frag_ready = 1'b1; inside_triangle = 1'b0;
    curr_x = '0; curr_y = '0;
    tif.bbox_min_x = '0; tif.bbox_min_y = '0; tif.bbox_max_x = '0; tif.bbox_max_y = '0;
    rand_edges();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({tif.tri_ready, busy, tri_done, do_idle, init_pos_e0, init_e1, init_e2, do_interpolate, step_x, step_y} !== 10'b10_0000_0000 || frag_count !== '0) begin
      bad++; $display("FAIL reset_state got %b cnt=%0d want 1000000000 cnt=0",
        {tif.tri_ready, busy, tri_done, do_idle, init_pos_e0, init_e1, init_e2, do_interpolate, step_x, step_y}, frag_count);
    end
    total++;
    if (smul_b1 !== '0 || smul_b2 !== '0) begin
      bad++; $display("FAIL reset_bbox got b1=%0d b2=%0d want 0/0", smul_b1, smul_b2);
    end
  endtask
  task automatic test_reset_mid_walk();
    int c;
    ins_mode = 0; stall_k = 0; stall_px_x = -1;
    @(posedge clk); #1;
    tif.bbox_min_x = 10'd0; tif.bbox_min_y = 10'd0; tif.bbox_max_x = 10'd1; tif.bbox_max_y = 10'd1;
    tif.tri_valid = 1'b1; inside_triangle = 1'b1; frag_valid = 1'b0; frag_ready = 1'b0;
    @(posedge clk); #1 tif.tri_valid = 1'b0;
    c = 0;
    while (c < 20 && do_interpolate !== 1'b1) begin @(negedge clk); c++; end
    total++;
    if (do_interpolate !== 1'b1) begin bad++; $display("FAIL midrst_reach_interp got %b want 1", do_interpolate); end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({tif.tri_ready, busy, tri_done, do_idle, init_pos_e0, init_e1, init_e2, do_interpolate, step_x, step_y} !== 10'b10_0000_0000 || frag_count !== '0) begin
      bad++; $display("FAIL midrst_state got %b cnt=%0d want 1000000000 cnt=0",
        {tif.tri_ready, busy, tri_done, do_idle, init_pos_e0, init_e1, init_e2, do_interpolate, step_x, step_y}, frag_count);
    end
    @(negedge clk);
    total++;
    if (tri_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_no_done got done=%b busy=%b want 0/0", tri_done, busy); end
    frag_ready = 1'b1;
    rand_edges();
    run_tri("midrst_after", 0, 0, 1, 1);
  endtask
  initial begin
    test_reset();
    ins_mode = 0; stall_k = 0; stall_px_x = -1; rand_edges();
    run_tri("basic_2x2", 0, 0, 1, 1);
    stall_k = 5; stall_px_x = 1; stall_px_y = 0; rand_edges();
    run_tri("stall_2x2", 0, 0, 1, 1);
    ins_mode = 1; stall_k = 0; stall_px_x = -1; rand_edges();
    run_tri("row_4x1", 0, 0, 3, 0);
    ins_mode = 0; rand_edges();
    run_tri("degen_x", 5, 0, 3, 2);
    run_tri("degen_y", 0, 9, 2, 8);
    rand_edges(); tif.edge1_A = COEF_W'(-3); tif.edge1_B = COEF_W'(7);
    run_tri("operands", 12, 4, 13, 4);
    ins_mode = 2; salt = 1; rand_edges();
    run_tri("edge_1023", 1021, 1022, 1023, 1023);
    test_reset_mid_walk();
    for (int t = 0; t < 24; t++) begin
      int mnx, mny;
      mnx = $urandom_range(0, 1019); mny = $urandom_range(0, 1019);
      ins_mode = $urandom_range(0, 2); salt = $urandom_range(0, 2);
      stall_k = $urandom_range(0, 3); stall_px_x = -1;
      rand_edges();
      if ($urandom_range(0, 5) == 0) run_tri("rand_degen", mnx + 2, mny, mnx, mny + $urandom_range(0, 2));
      else run_tri("rand", mnx, mny, mnx + $urandom_range(0, 3), mny + $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/raster_walk_ctrl.md
Name: raster_walk_ctrl

Overview:
Iteration controller for the rasterizer edge-walk datapath (UNIT-005.04). It accepts a set-up triangle (edge coefficients and bounding box), then sequences the edge walk's one-hot control strobes: init, edge test, interpolate/emit, step. It also owns the operand muxing for the shared setup multiplier during edge initialisation, and tracks per-triangle fragment count and completion.

Parameters:
COORD_W, 10, pixel coordinate width (x/y, bbox)
COEF_W, 11, edge A/B coefficient width (signed)
CNT_W, 16, fragment counter width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
tri_valid  in  1  set-up triangle available
tri_ready  out  1  controller idle, accepts triangle
bbox_min_x  in  COORD_W  bbox min X, sampled at accept
bbox_min_y  in  COORD_W  bbox min Y, sampled at accept
bbox_max_x  in  COORD_W  bbox max X, inclusive, sampled at accept
bbox_max_y  in  COORD_W  bbox max Y, inclusive, sampled at accept
edge0_A, edge0_B, edge1_A, edge1_B, edge2_A, edge2_B  in  COEF_W each  signed edge coefficients, held stable by setup while busy
smul_a1  out  COEF_W  multiplier 1 operand: selected edge A
smul_b1  out  COEF_W+1  multiplier 1 operand: {0,bbox_min_x}
smul_a2  out  COEF_W  multiplier 2 operand: selected edge B
smul_b2  out  COEF_W+1  multiplier 2 operand: {0,bbox_min_y}
do_idle, init_pos_e0, init_e1, init_e2, do_interpolate, step_x, step_y  out  1 each  edge-walk strobes
inside_triangle  in  1  from edge walk
curr_x, curr_y  in  COORD_W each  edge-walk iteration position
frag_valid  in  1  edge-walk fragment valid (observed)
frag_ready  in  1  downstream ready (observed)
busy  out  1  triangle in progress
tri_done  out  1  one-cycle pulse, triangle complete
frag_count  out  CNT_W  fragments emitted for current/last triangle

Behaviour:
- States: IDLE, ITER_START, INIT_E1, INIT_E2, EDGE_TEST, INTERPOLATE, ITER_NEXT. All strobes are Moore-decoded from state, except step_x/step_y/do_idle, which decode from ITER_NEXT plus the position compare.
- Reset (rst_n=0 at clk edge): state=IDLE, frag_count=0, latched bbox=0. Every strobe, busy and tri_done are 0; tri_ready=1. A mid-walk reset aborts the walk with no tri_done.
- IDLE: tri_ready=1. On tri_valid, latch bbox.
  - bbox_max_x<bbox_min_x or bbox_max_y<bbox_min_y (degenerate): next cycle pulse tri_done, frag_count=0, stay IDLE; no strobes.
  - Otherwise: frag_count<=0, go to ITER_START.
- ITER_START: init_pos_e0=1; operands = edge0_A/B. Next INIT_E1.
- INIT_E1: init_e1=1; operands = edge1_A/B. Next INIT_E2.
- INIT_E2: init_e2=1; operands = edge2_A/B. Next EDGE_TEST.
- Operands outside the init states: edge0 selection, for stable toggling only.
- EDGE_TEST: inside_triangle=1 goes to INTERPOLATE, else ITER_NEXT.
- INTERPOLATE: do_interpolate=1 every cycle in state. Exit to ITER_NEXT in the cycle frag_valid&&frag_ready, and increment frag_count (saturating) in that cycle. With frag_ready=0, hold indefinitely.
- ITER_NEXT:
  - curr_x<max_x: step_x, go to EDGE_TEST.
  - Else curr_y<max_y: step_y, go to EDGE_TEST.
  - Else: do_idle=1 and tri_done=1 (same cycle), go to IDLE.
  - step_x and step_y are never both 1.
- busy = state!=IDLE. Per-pixel cost: outside 2 cycles; inside with ready 4 cycles.
- Compares are unsigned COORD_W. max=1023 does not wrap, because the step is gated by <.

Decomposition:
- raster_pkg: raster_walk_state_t enum; COORD_W/COEF_W defaults; edge-select enum (EDGE0..EDGE2).
- One sub-module is natural: raster_smul_opsel, the combinational 3:1 A/B operand mux keyed by edge-select. Everything else stays in raster_walk_ctrl.

Test Plan:
- 2x2 bbox (0,0)-(1,1), inside=1 always, frag_ready=1, accept at cycle 0 -> init strobes at cycles 1/2/3, four fragments, tri_done and do_idle at cycle 19, tri_ready=1 at cycle 20, frag_count=4.
- Same triangle, frag_ready=0 for 5 cycles on pixel (1,0) -> do_interpolate held, no step, exit only on valid&&ready, frag_count=4.
- 4x1 bbox, inside=1 only at x=2 -> strobe sequence step_x x3, one INTERPOLATE, no step_y, frag_count=1.
- Degenerate bbox min_x=5, max_x=3 -> tri_done one cycle after accept, no init/step strobes, frag_count=0.
- Operand check with edge1_A=-3, edge1_B=7, bbox_min=(12,4) -> in INIT_E1, smul_a1=-3, smul_b1=12, smul_a2=7, smul_b2=4.
- rst_n=0 during INTERPOLATE -> next cycle IDLE, tri_ready=1, all strobes 0, no tri_done; next triangle walks normally.
